// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner codes and the
// full-word byte-enable mask.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_D   = 1'b1;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data ports, with a streak counter that forces a
// pending fetch through after STARVE_LIMIT back-to-back data grants.
module mem_arb_grant #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic grant_i,
    output logic grant_d_o
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0] streak_q, streak_d;

    assign grant_d_o = d_req_i && !(if_req_i && (streak_q == Limit));

    always_comb begin
        streak_d = streak_q;
        if (grant_i) begin
            if (grant_d_o && if_req_i) begin
                streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data port has priority over instruction fetch, a
// starvation guard bounds fetch latency, and a ready timeout aborts stuck accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic        d_sign,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        busy,
    output logic        mem_cs,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic        mem_sign,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [7:0] TimeoutW = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic        rw_q, rw_d;
    logic        sign_q, sign_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;

    logic        grant;
    logic        grant_d;
    logic [7:0]  wait_inc;

    assign grant    = (state_q == StIdle) && (if_req || d_req);
    assign wait_inc = wait_q + 8'd1;

    mem_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .if_req_i (if_req),
        .d_req_i  (d_req),
        .grant_i  (grant),
        .grant_d_o(grant_d)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant) state_d = StAccess;
            StAccess: if (mem_ready || (wait_inc == TimeoutW)) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_d    = owner_q;
        addr_d     = addr_q;
        be_d       = be_q;
        rw_d       = rw_q;
        sign_d     = sign_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        wait_d     = wait_q;
        err_d      = err_q;
        if (grant) begin
            owner_d = grant_d ? OWN_D : OWN_IF;
            addr_d  = grant_d ? d_addr : if_addr;
            be_d    = grant_d ? d_be : BE_WORD;
            rw_d    = grant_d ? d_rw : 1'b0;
            sign_d  = grant_d ? d_sign : 1'b0;
            wdata_d = grant_d ? d_wdata : 32'd0;
            wait_d  = 8'd0;
            err_d   = 1'b0;
        end else if (state_q == StAccess) begin
            if (mem_ready) begin
                if (!rw_q) begin
                    if (owner_q == OWN_D) d_rdata_d = mem_rdata;
                    else                  if_rdata_d = mem_rdata;
                end
            end else begin
                wait_d = wait_inc;
                if (wait_inc == TimeoutW) err_d = 1'b1;
            end
        end else if (state_q == StDone) begin
            wait_d = 8'd0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner_q    <= OWN_IF;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            rw_q       <= 1'b0;
            sign_q     <= 1'b0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            wait_q     <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            rw_q       <= rw_d;
            sign_q     <= sign_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

    // Outputs decode from state so an asynchronous reset clears them immediately.
    always_comb begin
        mem_cs    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = 32'd0;
        mem_be    = 4'd0;
        mem_sign  = 1'b0;
        mem_wdata = 32'd0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            StAccess: begin
                mem_cs    = 1'b1;
                mem_rw    = rw_q;
                mem_addr  = addr_q;
                mem_be    = be_q;
                mem_sign  = sign_q;
                mem_wdata = wdata_q;
            end
            StDone: begin
                if_ack = (owner_q == OWN_IF);
                d_ack  = (owner_q == OWN_D);
                err    = err_q;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small negedge-sampling memory model that
// applies byte enables and sign extension on reads.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [3:0]  d_be = 4'd0;
    logic        d_sign = 1'b0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        busy;
    logic        mem_cs;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_sign;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready;
    logic        ready_en = 1'b1;

    logic [31:0] mem [0:15];
    int total = 0;
    int bad = 0;

    assign mem_ready = ready_en;

    always #5 Clk = ~Clk;

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (15)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_rw     (d_rw),
        .d_addr   (d_addr),
        .d_be     (d_be),
        .d_sign   (d_sign),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .err      (err),
        .busy     (busy),
        .mem_cs   (mem_cs),
        .mem_rw   (mem_rw),
        .mem_addr (mem_addr),
        .mem_be   (mem_be),
        .mem_sign (mem_sign),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [3:0] be,
                                        input logic sg);
        case (be)
            4'hF:    return w;
            4'h3:    return sg ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            4'h1:    return sg ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
            default: return w & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        endcase
    endfunction

    // Memory writes on RW regardless of CS, like the real part.
    always @(negedge Clk) begin
        if (mem_rw) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
        if (mem_cs && !mem_rw) mem_rdata <= fmt(mem[mem_addr[5:2]], mem_be, mem_sign);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            check("ack_exclusive", {31'd0, if_ack & d_ack}, 32'd0);
            check("rw_outside_access", {31'd0, mem_rw & ~mem_cs}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic exp_d [0:5];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[1] = 32'hA5A5_0001;
        mem[2] = 32'h2008_BFC0;
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
        exp_d[3] = 1'b1; exp_d[4] = 1'b0; exp_d[5] = 1'b1;

        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        Reset = 1'b0;

        // Fetch only
        if_req = 1'b1;
        if_addr = 32'h8;
        tick();
        check("f_cs", {31'd0, mem_cs}, 32'd1);
        check("f_rw", {31'd0, mem_rw}, 32'd0);
        check("f_be", {28'd0, mem_be}, 32'hF);
        check("f_addr", mem_addr, 32'h8);
        check("f_early_ack", {31'd0, if_ack}, 32'd0);
        tick();
        check("f_ack", {31'd0, if_ack}, 32'd1);
        check("f_cs_done", {31'd0, mem_cs}, 32'd0);
        check("f_rdata", if_rdata, 32'h2008_BFC0);
        if_req = 1'b0;
        tick();
        check("f_ack_pulse", {31'd0, if_ack}, 32'd0);
        check("f_idle", {31'd0, busy}, 32'd0);

        // Store then sign-extending halfword load
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h0; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("st_rw", {31'd0, mem_rw}, 32'd1);
        check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("st_ack", {31'd0, d_ack}, 32'd1);
        check("st_err", {31'd0, err}, 32'd0);
        check("st_rdata_kept", d_rdata, 32'd0);
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_rw = 1'b0; d_be = 4'h3; d_sign = 1'b1;
        tick();
        check("ld_be", {28'd0, mem_be}, 32'h3);
        check("ld_sign", {31'd0, mem_sign}, 32'd1);
        tick();
        check("ld_ack", {31'd0, d_ack}, 32'd1);
        check("ld_rdata", d_rdata, 32'hFFFF_BEEF);
        d_req = 1'b0;
        tick();

        // Both ports held: starvation guard lets fetch through after 4 data grants
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h0; d_be = 4'hF; d_sign = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            tick();
            check($sformatf("arb_d_ack%0d", k), {31'd0, d_ack}, {31'd0, exp_d[k]});
            check($sformatf("arb_if_ack%0d", k), {31'd0, if_ack}, {31'd0, ~exp_d[k]});
            tick();
        end
        check("arb_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("arb_if_rdata", if_rdata, 32'h2008_BFC0);
        if_req = 1'b0;
        d_req = 1'b0;
        tick();

        // Ready timeout: 15 ACCESS cycles then ack with err, rdata untouched
        ready_en = 1'b0;
        d_req = 1'b1; d_addr = 32'h8;
        tick();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("to_cs%0d", i), {30'd0, mem_cs, d_ack}, 32'h2);
            tick();
        end
        check("to_ack", {31'd0, d_ack}, 32'd1);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        tick();
        check("to_idle", {30'd0, busy, err}, 32'd0);
        ready_en = 1'b1;

        // Asynchronous reset in the middle of a write
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h4; d_wdata = 32'h1234_5678;
        tick();
        check("rs_rw_before", {31'd0, mem_rw}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("rs_cs", {31'd0, mem_cs}, 32'd0);
        check("rs_rw", {31'd0, mem_rw}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_rdata", d_rdata, 32'd0);
        tick();
        check("rs_no_ack", {30'd0, d_ack, if_ack}, 32'd0);
        Reset = 1'b0;
        d_rw = 1'b0;
        tick();
        check("rs_after_cs", {31'd0, mem_cs}, 32'd1);
        tick();
        check("rs_after_ack", {31'd0, d_ack}, 32'd1);
        check("rs_after_rdata", d_rdata, 32'hA5A5_0001);
        d_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch unit (read-only, word) and the load/store unit (read/write, byte-enabled, sign-extending loads).
- Posedge-clocked request/ack front end; drives the memory's CS/RW/Addr/BE/DataIn/MemSign, which the memory samples on the negedge inside the access cycle.
- Data port has priority; a starvation guard bounds fetch latency. A ready-timeout reports a stuck memory.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants with fetch pending before fetch is forced through (1..15).
- TIMEOUT, 15: ACCESS cycles without mem_ready before the access aborts with err (1..255).

Ports:
- Clk  in  1  system clock, all state on posedge
- Reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle pulse, fetch complete
- if_rdata  out  32  fetched word, valid from if_ack until next fetch ack
- d_req  in  1  data request, held until d_ack
- d_rw  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_be  in  4  byte enables
- d_sign  in  1  sign-extend partial loads
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  32  load result, valid from d_ack until next data ack
- err  out  1  one-cycle pulse coincident with an ack when that access timed out
- busy  out  1  state != IDLE
- mem_cs, mem_rw  out  1 each  memory chip select / write strobe
- mem_addr  out  32; mem_be  out  4; mem_sign  out  1; mem_wdata  out  32
- mem_rdata  in  32; mem_ready  in  1

Behaviour:
- States: IDLE, ACCESS, DONE. Reset (any time, including mid-access): IDLE, all outputs 0, both rdata regs 0, streak 0, wait count 0. Access in flight is dropped with no ack.
- IDLE: no req -> stay. Otherwise grant: data if d_req and not (if_req and streak == STARVE_LIMIT), else fetch. Latch owner, addr, be, rw, sign, wdata (fetch: be = 4'b1111, rw = 0, sign = 0, wdata = 0). -> ACCESS.
- Streak: data grant with if_req high -> streak+1 (saturating). Data grant with if_req low -> 0. Any fetch grant -> 0.
- ACCESS: mem_cs = 1. mem_addr/be/sign/wdata/rw are driven from latched regs.
  - mem_ready at posedge -> capture mem_rdata into the owner's rdata reg on reads (writes leave it unchanged), then -> DONE.
  - Else wait+1. If wait reaches TIMEOUT -> DONE with err flagged; rdata is unchanged.
- DONE: owner's ack = 1 for exactly this cycle, err = flag, wait cleared. -> IDLE.
- Requests are not sampled in ACCESS or DONE. Requester drops req in the cycle after ack; a req still high in IDLE is a new request.
- Outside ACCESS, all mem_* outputs = 0. mem_rw = 1 only in ACCESS with a latched write; the memory writes on RW regardless of CS.
- Latency: req high in IDLE cycle n -> ack in cycle n+2 with mem_ready = 1. Throughput is 1 access per 3 cycles.
- Simultaneous if_req and d_req: data wins unless the streak limit is reached. Exactly one ack per granted access; if_ack and d_ack are never high together.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2), OWN_IF/OWN_D, BE_WORD = 4'b1111.
- Sub-module mem_arb_grant: combinational grant decision plus the streak counter (inputs if_req, d_req, grant strobe; outputs grant_d).
- FSM, latches and timeout counter live in the top.

Test Plan:
- Fetch only, if_addr = 32'h8, memory word 2 = 32'h2008BFC0, ready = 1 -> mem_cs high exactly 1 cycle, mem_rw = 0, mem_be = 4'hF; if_ack 2 cycles after req; if_rdata = 32'h2008BFC0.
- Store d_addr = 0, d_be = 4'hF, d_wdata = 32'hDEADBEEF, then load same address with d_be = 4'h3, d_sign = 1 -> second d_ack has d_rdata = 32'hFFFFBEEF; mem_rw is 0 in every non-ACCESS cycle.
- if_req and d_req both held high continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, IF, D...; if_ack never together with d_ack.
- mem_ready tied 0, TIMEOUT = 15 -> 15 ACCESS cycles, then d_ack = 1 with err = 1, d_rdata unchanged, FSM returns to IDLE.
- Reset asserted mid-ACCESS of a write -> all outputs 0 immediately (async), no ack, mem_rw = 0; first request after release is served normally.
